// File: rtl/register_snapshot_reader.sv
// Captures a bank of NUM_REGS registers on start and streams the snapshot out one beat per valid/ready transfer.
// Optional `REGISTER_SNAPSHOT_READER_PARITY_EN adds out_parity, a per-entry XOR of the captured data.
module register_snapshot_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int IDX_WIDTH  = (NUM_REGS > 1 ? $clog2(NUM_REGS) : 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_values,
  output logic                           busy,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [IDX_WIDTH-1:0]           out_index,
  output logic                           out_last,
  output logic                           done
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
  ,
  output logic                           out_parity
`endif
);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_STREAM = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REGS - 1);

  logic [0:0]            state;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] snap [NUM_REGS];
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
  logic                  snap_par [NUM_REGS];
`endif

  logic xfer;
  logic at_last;

  assign xfer    = out_valid && out_ready;
  assign at_last = (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // the snapshot buffer is reset too, so the bank reads back as zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= STATE_IDLE;
      idx    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        snap[i] <= '0;
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
        snap_par[i] <= 1'b0;
`endif
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        STATE_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              snap[i] <= reg_values[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
              snap_par[i] <= ^reg_values[i*DATA_WIDTH +: DATA_WIDTH];
`endif
            end
            idx   <= '0;
            state <= STATE_STREAM;
          end
        end
        STATE_STREAM: begin
          // start is deliberately not looked at here, even on the final transfer.
          if (xfer) begin
            if (at_last) begin
              state  <= STATE_IDLE;
              idx    <= '0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign out_valid = (state == STATE_STREAM);
  assign busy      = out_valid;
  assign out_index = idx;
  assign out_last  = out_valid && at_last;
  assign done      = done_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    out_data = '0;
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
    out_parity = 1'b0;
`endif
    if (out_valid) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx == IDX_WIDTH'(i)) begin
          out_data = snap[i];
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
          out_parity = snap_par[i];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_register_snapshot_reader.sv
// Directed bench for register_snapshot_reader: a 4-register instance and a 1-register instance.
module tb_register_snapshot_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        out_ready;
  logic [31:0] reg_values;
  logic        busy, out_valid, out_last, done;
  logic [7:0]  out_data;
  logic [1:0]  out_index;

  logic        start_s;
  logic        out_ready_s;
  logic [7:0]  reg_values_s;
  logic        busy_s, out_valid_s, out_last_s, done_s;
  logic [7:0]  out_data_s;
  logic [0:0]  out_index_s;

`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
  logic out_parity, out_parity_s;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] exp_b [4] = '{8'h55, 8'h66, 8'h77, 8'h88};

  register_snapshot_reader #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .reg_values(reg_values),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .done(done)
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  register_snapshot_reader #(.DATA_WIDTH(8), .NUM_REGS(1)) dut_single (
    .clk(clk), .rst(rst), .start(start_s), .reg_values(reg_values_s),
    .busy(busy_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_data(out_data_s), .out_index(out_index_s), .out_last(out_last_s), .done(done_s)
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
    , .out_parity(out_parity_s)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; reg_values = '0;
    start_s = 1'b0; out_ready_s = 1'b0; reg_values_s = '0;
    #1;
    checks++;
    if ({busy, out_valid, out_data, out_index, out_last, done} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, out_valid, out_data, out_index, out_last, done});
    end
    checks++;
    if ({busy_s, out_valid_s, out_data_s, out_index_s, out_last_s, done_s} !== 13'h0) begin
      failures++;
      $display("FAIL reset_outputs_single got=%h exp=0",
               {busy_s, out_valid_s, out_data_s, out_index_s, out_last_s, done_s});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, out_valid, done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=000", {busy, out_valid, done});
    end
  endtask

  task automatic test_basic_stream();
    reg_values = 32'h44332211; out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, busy, out_data, out_index, out_last, done} !==
          {1'b1, 1'b1, exp_a[i], 2'(i), (i == 3), 1'b0}) begin
        failures++;
        $display("FAIL basic_beat%0d got v=%b b=%b d=%h i=%0d l=%b dn=%b exp d=%h i=%0d l=%b",
                 i, out_valid, busy, out_data, out_index, out_last, done, exp_a[i], i, (i == 3));
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, busy, done, out_last} !== 4'b0010) begin
      failures++;
      $display("FAIL basic_done got v/b/dn/l=%b exp=0010", {out_valid, busy, done, out_last});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_snapshot_isolation();
    reg_values = 32'h44332211; out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    reg_values = 32'h44FF2211;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data, out_index} !== {1'b1, exp_a[i], 2'(i)}) begin
        failures++;
        $display("FAIL isolation_beat%0d got v=%b d=%h i=%0d exp d=%h", i, out_valid, out_data, out_index, exp_a[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL isolation_done got=%b exp=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic pat [3] = '{1'b1, 1'b0, 1'b0};
    int cnt = 0;
    reg_values = 32'h44332211; out_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 40 && cnt < 4; cyc++) begin
      checks++;
      if ({out_valid, out_data, out_index, out_last, done} !== {1'b1, exp_a[cnt], 2'(cnt), (cnt == 3), 1'b0}) begin
        failures++;
        $display("FAIL backpressure_cyc%0d got v=%b d=%h i=%0d l=%b dn=%b exp d=%h i=%0d",
                 cyc, out_valid, out_data, out_index, out_last, done, exp_a[cnt], cnt);
      end
      out_ready = pat[cyc % 3];
      if (out_ready) cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== 4) begin
      failures++;
      $display("FAIL backpressure_transfers got=%0d exp=4", cnt);
    end
    checks++;
    if ({out_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL backpressure_done got v/b/dn=%b exp=001", {out_valid, busy, done});
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    reg_values = 32'h44332211; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    reg_values = 32'h88776655;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data, out_index} !== {1'b1, exp_a[i], 2'(i)}) begin
        failures++;
        $display("FAIL ignored_start_beat%0d got v=%b d=%h i=%0d exp d=%h", i, out_valid, out_data, out_index, exp_a[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, done} !== 2'b01) begin
      failures++;
      $display("FAIL ignored_start_idle got v/dn=%b exp=01", {out_valid, done});
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data, out_index, done} !== {1'b1, exp_b[i], 2'(i), 1'b0}) begin
        failures++;
        $display("FAIL restart_beat%0d got v=%b d=%h i=%0d dn=%b exp d=%h",
                 i, out_valid, out_data, out_index, done, exp_b[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, done} !== 2'b01) begin
      failures++;
      $display("FAIL restart_done got v/dn=%b exp=01", {out_valid, done});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    reg_values = 32'h44332211; out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_index} !== {1'b1, 2'd2}) begin
      failures++;
      $display("FAIL midreset_pre got v=%b i=%0d exp v=1 i=2", out_valid, out_index);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, out_valid, out_data, out_index, out_last, done} !== 14'h0) begin
      failures++;
      $display("FAIL midreset_async got=%h exp=0", {busy, out_valid, out_data, out_index, out_last, done});
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, done} !== 2'b00) begin
        failures++;
        $display("FAIL midreset_no_done%0d got v/dn=%b exp=00", i, {out_valid, done});
      end
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data, out_index} !== {1'b1, exp_a[i], 2'(i)}) begin
        failures++;
        $display("FAIL midreset_fresh_beat%0d got v=%b d=%h i=%0d exp d=%h", i, out_valid, out_data, out_index, exp_a[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_fresh_done got=%b exp=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_single_reg();
    logic [7:0] vals [2] = '{8'hA5, 8'hA4};
    logic       pars [2] = '{1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      reg_values_s = vals[k]; out_ready_s = 1'b1; start_s = 1'b1;
      @(negedge clk); start_s = 1'b0;
      reg_values_s = 8'h00;
      checks++;
      if ({out_valid_s, busy_s, out_data_s, out_index_s, out_last_s} !== {1'b1, 1'b1, vals[k], 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL single_beat%0d got v=%b b=%b d=%h i=%0d l=%b exp d=%h l=1",
                 k, out_valid_s, busy_s, out_data_s, out_index_s, out_last_s, vals[k]);
      end
`ifdef REGISTER_SNAPSHOT_READER_PARITY_EN
      checks++;
      if (out_parity_s !== pars[k]) begin
        failures++;
        $display("FAIL single_parity%0d got=%b exp=%b", k, out_parity_s, pars[k]);
      end
`else
      if (pars[k] === 1'bx) $display("unexpected parity table entry");
`endif
      @(negedge clk);
      checks++;
      if ({out_valid_s, busy_s, done_s} !== 3'b001) begin
        failures++;
        $display("FAIL single_done%0d got v/b/dn=%b exp=001", k, {out_valid_s, busy_s, done_s});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_snapshot_isolation();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_stream();
    test_single_reg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
